// File: rtl/hdmi_timing_gen.sv
// Parametrised video timing generator with a pixel-pipeline aligner so that de/hs/vs/rgb leave
// the block together, PIX_LATENCY cycles after the matching pixel request.
module hdmi_timing_gen #(
  parameter int unsigned         BPC         = 1,
  parameter int unsigned         H_ACTIVE    = 800,
  parameter int unsigned         H_FP        = 56,
  parameter int unsigned         H_SYNC      = 120,
  parameter int unsigned         H_BP        = 64,
  parameter bit                  H_POL       = 1'b1,
  parameter int unsigned         V_ACTIVE    = 600,
  parameter int unsigned         V_FP        = 37,
  parameter int unsigned         V_SYNC      = 6,
  parameter int unsigned         V_BP        = 23,
  parameter bit                  V_POL       = 1'b1,
  parameter int unsigned         PIX_LATENCY = 1,
  parameter logic [3*BPC-1:0]    BLANK_RGB   = '1
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               en,
  input  logic               pattern_sel,
  output logic [9:0]         x,
  output logic [9:0]         y,
  output logic               req,
  output logic               line_start,
  output logic               frame_start,
  input  logic [3*BPC-1:0]   pixel_data,
  output logic [3*BPC-1:0]   rgb,
  output logic               de,
  output logic               hs,
  output logic               vs,
  output logic               clk_out
);

  localparam int unsigned H_TOTAL = H_FP + H_SYNC + H_BP + H_ACTIVE;
  localparam int unsigned V_TOTAL = V_FP + V_SYNC + V_BP + V_ACTIVE;
  localparam logic [15:0] HS_BEG  = 16'(H_FP);
  localparam logic [15:0] HS_END  = 16'(H_FP + H_SYNC);
  localparam logic [15:0] HA_BEG  = 16'(H_FP + H_SYNC + H_BP);
  localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
  localparam logic [15:0] VS_BEG  = 16'(V_FP);
  localparam logic [15:0] VS_END  = 16'(V_FP + V_SYNC);
  localparam logic [15:0] VA_BEG  = 16'(V_FP + V_SYNC + V_BP);
  localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);

  if (H_ACTIVE > 1024 || V_ACTIVE > 1024 || PIX_LATENCY > 8) begin : g_param_check
    $error("hdmi_timing_gen: active area must be <= 1024 and PIX_LATENCY <= 8");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_t;

  state_t      state_q, state_d;
  logic [15:0] h_q, h_d, v_q, v_d;
  logic        frame_end;

  // Stage-0 decodes of the current counter value
  logic        act0, hs0, vs0, ls0, fs0;
  logic [15:0] col0;
  logic [9:0]  row0;
  logic [2:0]  bar0;

  // Index 0 is the request stage; index PIX_LATENCY drives the PMOD
  logic [PIX_LATENCY:0] de_p, hs_p, vs_p, sel_p;
  logic [2:0]           bar_p [PIX_LATENCY+1];
  logic [9:0]           x_q, y_q;
  logic                 ls_q, fs_q;

  assign frame_end = (h_q == H_LAST) && (v_q == V_LAST);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q <= StIdle;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StRun;
      StRun:   if (!en && frame_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (state_q == StRun) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 16'd1;
      end else begin
        h_d = h_q + 16'd1;
      end
    end
  end

  always_comb begin
    act0 = (state_q == StRun) && (h_q >= HA_BEG) && (v_q >= VA_BEG);
    hs0  = (state_q == StRun) && (h_q >= HS_BEG) && (h_q < HS_END);
    vs0  = (state_q == StRun) && (v_q >= VS_BEG) && (v_q < VS_END);
    col0 = h_q - HA_BEG;
    row0 = 10'(v_q - VA_BEG);
    ls0  = act0 && (h_q == HA_BEG);
    fs0  = ls0 && (v_q == VA_BEG);
    // floor(col*8/H_ACTIVE) as a threshold count, avoiding a divider
    bar0 = '0;
    for (int unsigned b = 1; b < 8; b++) begin
      if ({13'd0, col0, 3'd0} >= 32'(b * H_ACTIVE)) bar0 = 3'(b);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      de_p  <= '0;
      hs_p  <= '0;
      vs_p  <= '0;
      sel_p <= '0;
      for (int i = 0; i <= PIX_LATENCY; i++) bar_p[i] <= '0;
      x_q   <= '0;
      y_q   <= '0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      de_p[0]  <= act0;
      hs_p[0]  <= hs0;
      vs_p[0]  <= vs0;
      sel_p[0] <= pattern_sel;
      bar_p[0] <= bar0;
      x_q      <= act0 ? col0[9:0] : '0;
      y_q      <= act0 ? row0 : '0;
      ls_q     <= ls0;
      fs_q     <= fs0;
      for (int i = 1; i <= PIX_LATENCY; i++) begin
        de_p[i]  <= de_p[i-1];
        hs_p[i]  <= hs_p[i-1];
        vs_p[i]  <= vs_p[i-1];
        sel_p[i] <= sel_p[i-1];
        bar_p[i] <= bar_p[i-1];
      end
    end
  end

  always_comb begin
    req         = de_p[0];
    x           = x_q;
    y           = y_q;
    line_start  = ls_q;
    frame_start = fs_q;
    de          = de_p[PIX_LATENCY];
    hs          = hs_p[PIX_LATENCY] ? H_POL : ~H_POL;
    vs          = vs_p[PIX_LATENCY] ? V_POL : ~V_POL;
    rgb         = BLANK_RGB;
    if (de) begin
      rgb = sel_p[PIX_LATENCY] ? {{BPC{bar_p[PIX_LATENCY][2]}}, {BPC{bar_p[PIX_LATENCY][1]}},
                                  {BPC{bar_p[PIX_LATENCY][0]}}}
                               : pixel_data;
    end
  end

  assign clk_out = clk_in;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen with a tiny 14x7 raster; a timing model predicts every output per
// cycle and a scoreboard matches each request's expected pixel against the rgb it produces.
module tb_hdmi_timing_gen;

  localparam int HT   = 14;
  localparam int FT   = 98;
  localparam int HUGE = 32'h3fff_ffff;

  logic       clk = 1'b0;
  logic       rst_n, en, pattern_sel;
  logic [9:0] x, y, x_n, y_n;
  logic       req, line_start, frame_start, de, hs, vs, clk_out;
  logic       req_n, ls_n, fs_n, de_n, hs_n, vs_n, clk_out_n;
  logic [2:0] pixel_data, rgb, rgb_n;
  logic [9:0] x_d1 = '0, x_d2 = '0, y_d1 = '0, y_d2 = '0;

  always #5 clk = ~clk;

  hdmi_timing_gen #(
    .BPC(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .H_POL(1'b1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .V_POL(1'b1), .PIX_LATENCY(2)
  ) u_dut (
    .clk_in(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel), .x(x), .y(y),
    .req(req), .line_start(line_start), .frame_start(frame_start), .pixel_data(pixel_data),
    .rgb(rgb), .de(de), .hs(hs), .vs(vs), .clk_out(clk_out)
  );

  hdmi_timing_gen #(
    .BPC(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .H_POL(1'b0),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .V_POL(1'b0), .PIX_LATENCY(2)
  ) u_dut_inv (
    .clk_in(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel), .x(x_n), .y(y_n),
    .req(req_n), .line_start(ls_n), .frame_start(fs_n), .pixel_data(pixel_data),
    .rgb(rgb_n), .de(de_n), .hs(hs_n), .vs(vs_n), .clk_out(clk_out_n)
  );

  // Pixel source: two-cycle read returning {x[1:0], y[0]}
  always @(posedge clk) begin
    x_d1 <= x;
    x_d2 <= x_d1;
    y_d1 <= y;
    y_d2 <= y_d1;
  end
  assign pixel_data = {x_d2[1:0], y_d2[0]};

  typedef struct {
    bit act, sh, sv, ls, fs;
    int xx, yy;
  } exp_t;

  typedef struct {
    logic [2:0] rgb;
    int         k;
  } sb_t;

  int  k = 0;
  int  k0 = HUGE;
  int  n_end = HUGE;
  int  n_checks = 0;
  int  n_pass = 0;
  sb_t sb_q[$];

  // Raster n counts pixel clocks since the run began; idle outside [0, n_end)
  function automatic exp_t model(input int n, input int lim);
    exp_t e = '{default: 0};
    int m, h, v;
    if (n >= 0 && n < lim) begin
      m    = n % FT;
      h    = m % HT;
      v    = m / HT;
      e.sh = (h >= 2 && h < 4);
      e.sv = (v == 1);
      e.act = (h >= 6 && v >= 3);
      if (e.act) begin
        e.xx = h - 6;
        e.yy = v - 3;
        e.ls = (h == 6);
        e.fs = (h == 6 && v == 3);
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", name, k, act, exp);
  endtask

  initial begin : monitor
    exp_t er, eo;
    sb_t  s;
    int   b;
    forever begin
      @(posedge clk);
      #1;
      k++;
      er = model(k - k0 - 1, n_end);
      eo = model(k - k0 - 3, n_end);
      chk("req", 32'(req), 32'(er.act));
      chk("x", 32'(x), er.xx);
      chk("y", 32'(y), er.yy);
      chk("line_start", 32'(line_start), 32'(er.ls));
      chk("frame_start", 32'(frame_start), 32'(er.fs));
      chk("de", 32'(de), 32'(eo.act));
      chk("hs", 32'(hs), 32'(eo.sh));
      chk("vs", 32'(vs), 32'(eo.sv));
      chk("hs_inv", 32'(hs_n), 32'(!eo.sh));
      chk("vs_inv", 32'(vs_n), 32'(!eo.sv));
      if (!rst_n) sb_q.delete();
      if (de === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("rgb_orphan", 32'(de), 32'd0);
        end else begin
          s = sb_q.pop_front();
          chk("rgb", 32'(rgb), 32'(s.rgb));
          chk("req_to_de", k - s.k, 2);
        end
      end else begin
        chk("rgb_blank", 32'(rgb), 32'h7);
      end
      if (er.act) begin
        b = er.xx * 8 / 8;
        s.rgb = pattern_sel ? 3'(b) : 3'((er.xx % 4) * 2 + (er.yy % 2));
        s.k   = k;
        sb_q.push_back(s);
      end
    end
  end

  initial begin : stimulus
    bit found;
    rst_n       = 1'b0;
    en          = 1'b1;
    pattern_sel = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    k0    = k + 1;
    repeat (200) @(negedge clk);

    pattern_sel = 1'b1;
    repeat (120) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      pattern_sel = ~pattern_sel;
      repeat (3) @(negedge clk);
    end
    pattern_sel = 1'b0;
    repeat (30) @(negedge clk);

    // Drop en mid-frame: the current frame must still finish
    n_end = ((k - k0) / FT + 1) * FT;
    en    = 1'b0;
    while (k < k0 + n_end + 12) @(negedge clk);
    en    = 1'b1;
    k0    = k + 1;
    n_end = HUGE;
    repeat (150) @(negedge clk);

    // Reset landing on the request for x=3 of an active line
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (model(k - k0, n_end).act && model(k - k0, n_end).xx == 3) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) chk("find_active_line", 32'd0, 32'd1);
    rst_n = 1'b0;
    k0    = HUGE;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k0    = k + 1;
    repeat (120) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
